// File: rtl/l2cache_control_pkg.sv
// Datapath mux select encodings shared with the L2 datapath, plus the controller state type.
package dimux;
    typedef enum logic {
        mem_wdata256_from_cpu = 1'b0,
        pmem_rdata_from_mem   = 1'b1
    } dimux_sel_t;
endpackage

package domux;
    typedef enum logic [1:0] {
        data_array_0 = 2'd0,
        data_array_1 = 2'd1,
        data_array_2 = 2'd2,
        data_array_3 = 2'd3
    } domux_sel_t;
endpackage

package addrmux;
    typedef enum logic [2:0] {
        mem_addr = 3'd0,
        cache_0  = 3'd1,
        cache_1  = 3'd2,
        cache_2  = 3'd3,
        cache_3  = 3'd4
    } addrmux_sel_t;
endpackage

package wemux;
    typedef enum logic [1:0] {
        zeros = 2'd0,
        ones  = 2'd1,
        mbe   = 2'd2
    } wemux_sel_t;
endpackage

package rv32i_types;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WB    = 2'd2,
        FILL  = 2'd3
    } l2ctrl_state_t;
endpackage

// File: rtl/l2cache_control_plru_victim.sv
// Tree-PLRU victim selection: PLRU bits point at the most recently used half/way.
module l2_plru_victim (
    input  logic [2:0]            lru_i,
    output logic [1:0]            way_o,
    output addrmux::addrmux_sel_t addr_sel_o,
    output domux::domux_sel_t     data_sel_o
);
    always_comb begin
        if (!lru_i[0]) way_o = lru_i[2] ? 2'd2 : 2'd3;
        else           way_o = lru_i[1] ? 2'd0 : 2'd1;
        unique case (way_o)
            2'd0:    begin addr_sel_o = addrmux::cache_0; data_sel_o = domux::data_array_0; end
            2'd1:    begin addr_sel_o = addrmux::cache_1; data_sel_o = domux::data_array_1; end
            2'd2:    begin addr_sel_o = addrmux::cache_2; data_sel_o = domux::data_array_2; end
            default: begin addr_sel_o = addrmux::cache_3; data_sel_o = domux::data_array_3; end
        endcase
    end
endmodule

// File: rtl/l2cache_control.sv
// L2 cache sequencing FSM: hit service, clean-miss fill, dirty-miss writeback then fill,
// with saturating hit/miss performance counters.
module l2cache_control
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic                   mem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    input  logic                   pmem_resp,
    input  logic [3:0]             hit_o,
    input  logic [3:0]             valid_o,
    input  logic [3:0]             dirty_o,
    input  logic [2:0]             lru_o,
    output dimux::dimux_sel_t      dimux_sel,
    output domux::domux_sel_t      domux_sel,
    output addrmux::addrmux_sel_t  addrmux_sel,
    output wemux::wemux_sel_t [3:0] wemux_sel,
    output logic [3:0]             valid_load,
    output logic [3:0]             dirty_load,
    output logic [3:0]             tag_load,
    output logic [3:0]             valid_i,
    output logic [3:0]             dirty_i,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);
    l2ctrl_state_t         state_q, state_d;
    logic [1:0]            vway_q, vway_d;
    addrmux::addrmux_sel_t vaddr_q, vaddr_d;
    domux::domux_sel_t     vdata_q, vdata_d;
    logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic [1:0]            plru_way;
    addrmux::addrmux_sel_t plru_addr;
    domux::domux_sel_t     plru_data;
    logic [1:0]            hit_way;
    domux::domux_sel_t     hit_data;

    l2_plru_victim u_victim (
        .lru_i      (lru_o),
        .way_o      (plru_way),
        .addr_sel_o (plru_addr),
        .data_sel_o (plru_data)
    );

    // hit_o is one-hot, so an OR-encoder gives the hitting way
    assign hit_way  = {hit_o[3] | hit_o[2], hit_o[3] | hit_o[1]};
    assign hit_data = domux::domux_sel_t'(hit_way);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            vway_q     <= '0;
            vaddr_q    <= addrmux::mem_addr;
            vdata_q    <= domux::data_array_0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vway_q     <= vway_d;
            vaddr_q    <= vaddr_d;
            vdata_q    <= vdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vway_d       = vway_q;
        vaddr_d      = vaddr_q;
        vdata_d      = vdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        dimux_sel    = dimux::mem_wdata256_from_cpu;
        domux_sel    = domux::data_array_0;
        addrmux_sel  = addrmux::mem_addr;
        wemux_sel[0] = wemux::zeros;
        wemux_sel[1] = wemux::zeros;
        wemux_sel[2] = wemux::zeros;
        wemux_sel[3] = wemux::zeros;
        valid_load   = '0;
        dirty_load   = '0;
        tag_load     = '0;
        valid_i      = '0;
        dirty_i      = '0;

        unique case (state_q)
            IDLE: if (mem_read || mem_write) state_d = CHECK;
            CHECK: begin
                if (!(mem_read || mem_write)) begin
                    state_d = IDLE;
                end else if (|hit_o) begin
                    mem_resp  = 1'b1;
                    domux_sel = hit_data;
                    if (mem_write) begin
                        wemux_sel[hit_way]  = wemux::mbe;
                        dirty_load[hit_way] = 1'b1;
                        dirty_i[hit_way]    = 1'b1;
                    end
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    vway_d  = plru_way;
                    vaddr_d = plru_addr;
                    vdata_d = plru_data;
                    state_d = (valid_o[plru_way] && dirty_o[plru_way]) ? WB : FILL;
                end
            end
            WB: begin
                pmem_write  = 1'b1;
                addrmux_sel = vaddr_q;
                domux_sel   = vdata_q;
                if (pmem_resp) begin
                    dirty_load[vway_q] = 1'b1;
                    state_d            = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                dimux_sel = dimux::pmem_rdata_from_mem;
                if (pmem_resp) begin
                    wemux_sel[vway_q]  = wemux::ones;
                    tag_load[vway_q]   = 1'b1;
                    valid_load[vway_q] = 1'b1;
                    valid_i[vway_q]    = 1'b1;
                    dirty_load[vway_q] = 1'b1;
                    state_d            = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst && state_q == CHECK) begin
            assert ($onehot0(hit_o)) else $error("hit_o has more than one way set");
        end
    end
endmodule

// File: tb/tb_l2cache_control.sv
// Directed bench for l2cache_control: per-cycle comparison against a transaction-level model.
module tb_l2cache_control;
    logic clk = 1'b0;
    logic rst, mem_read, mem_write, pmem_resp;
    logic [3:0] hit_o, valid_o, dirty_o;
    logic [2:0] lru_o;

    logic mem_resp, pmem_read, pmem_write;
    dimux::dimux_sel_t dimux_sel;
    domux::domux_sel_t domux_sel;
    addrmux::addrmux_sel_t addrmux_sel;
    wemux::wemux_sel_t [3:0] wemux_sel;
    logic [3:0] valid_load, dirty_load, tag_load, valid_i, dirty_i;
    logic [31:0] hit_count, miss_count;

    logic s_mem_resp, s_pmem_read, s_pmem_write;
    dimux::dimux_sel_t s_dimux_sel;
    domux::domux_sel_t s_domux_sel;
    addrmux::addrmux_sel_t s_addrmux_sel;
    wemux::wemux_sel_t [3:0] s_wemux_sel;
    logic [3:0] s_valid_load, s_dirty_load, s_tag_load, s_valid_i, s_dirty_i;
    logic [1:0] s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    l2cache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit_o(hit_o), .valid_o(valid_o), .dirty_o(dirty_o),
        .lru_o(lru_o), .dimux_sel(dimux_sel), .domux_sel(domux_sel),
        .addrmux_sel(addrmux_sel), .wemux_sel(wemux_sel), .valid_load(valid_load),
        .dirty_load(dirty_load), .tag_load(tag_load), .valid_i(valid_i),
        .dirty_i(dirty_i), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter copy driven by the same stimulus to exercise saturation.
    l2cache_control #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_resp(pmem_resp), .hit_o(hit_o), .valid_o(valid_o), .dirty_o(dirty_o),
        .lru_o(lru_o), .dimux_sel(s_dimux_sel), .domux_sel(s_domux_sel),
        .addrmux_sel(s_addrmux_sel), .wemux_sel(s_wemux_sel), .valid_load(s_valid_load),
        .dirty_load(s_dirty_load), .tag_load(s_tag_load), .valid_i(s_valid_i),
        .dirty_i(s_dirty_i), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_on = 1'b0;
    logic        e_resp, e_pr, e_pw, e_di;
    logic [1:0]  e_do;
    logic [2:0]  e_am;
    logic [7:0]  e_we;
    logic [3:0]  e_vl, e_dl, e_tl, e_vi, e_dii;
    logic [31:0] m_hits, m_miss;
    logic        pend_hit, pend_miss;

    // Victim per PLRU pattern, worked out by hand from the tree rule.
    logic [1:0] vict_tab [8] = '{2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0};

    function automatic logic [1:0] data_of(input logic [1:0] w);
        case (w)
            2'd0:    return domux::data_array_0;
            2'd1:    return domux::data_array_1;
            2'd2:    return domux::data_array_2;
            default: return domux::data_array_3;
        endcase
    endfunction

    function automatic logic [2:0] addr_of(input logic [1:0] w);
        case (w)
            2'd0:    return addrmux::cache_0;
            2'd1:    return addrmux::cache_1;
            2'd2:    return addrmux::cache_2;
            default: return addrmux::cache_3;
        endcase
    endfunction

    function automatic logic [31:0] sat2(input logic [31:0] x);
        return (x > 32'd3) ? 32'd3 : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("mem_resp",    32'(mem_resp),    32'(e_resp));
            chk("pmem_read",   32'(pmem_read),   32'(e_pr));
            chk("pmem_write",  32'(pmem_write),  32'(e_pw));
            chk("dimux_sel",   32'(dimux_sel),   32'(e_di));
            chk("domux_sel",   32'(domux_sel),   32'(e_do));
            chk("addrmux_sel", 32'(addrmux_sel), 32'(e_am));
            chk("wemux_sel",   32'(wemux_sel),   32'(e_we));
            chk("valid_load",  32'(valid_load),  32'(e_vl));
            chk("dirty_load",  32'(dirty_load),  32'(e_dl));
            chk("tag_load",    32'(tag_load),    32'(e_tl));
            chk("valid_i",     32'(valid_i),     32'(e_vi));
            chk("dirty_i",     32'(dirty_i),     32'(e_dii));
            chk("hit_count",   hit_count,        m_hits);
            chk("miss_count",  miss_count,       m_miss);
            chk("sat_hit_count",  32'(s_hit_count),  sat2(m_hits));
            chk("sat_miss_count", 32'(s_miss_count), sat2(m_miss));
        end
    end

    task automatic exp_default();
        e_resp = 1'b0; e_pr = 1'b0; e_pw = 1'b0;
        e_di = dimux::mem_wdata256_from_cpu;
        e_do = domux::data_array_0;
        e_am = addrmux::mem_addr;
        e_we = '0;
        e_vl = '0; e_dl = '0; e_tl = '0; e_vi = '0; e_dii = '0;
    endtask

    // Advance one cycle; counter effects of the previous cycle become visible now.
    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (!r) begin
            m_hits = '0;
            m_miss = '0;
        end else begin
            if (pend_hit  && m_hits != '1) m_hits = m_hits + 1;
            if (pend_miss && m_miss != '1) m_miss = m_miss + 1;
        end
        pend_hit = 1'b0;
        pend_miss = 1'b0;
        exp_default();
    endtask

    task automatic hit_cycle(input logic wr, input logic [1:0] w);
        e_resp = 1'b1;
        e_do = data_of(w);
        if (wr) begin
            e_we[{w, 1'b0} +: 2] = wemux::mbe;
            e_dl[w] = 1'b1;
            e_dii[w] = 1'b1;
        end
        pend_hit = 1'b1;
    endtask

    // kind: 1 read, 2 write, 3 both; hitway < 0 means miss.
    task automatic txn(input int kind, input int hitway, input logic [2:0] lru,
                       input logic [3:0] val, input logic [3:0] dty,
                       input int wbn, input int filln);
        logic [1:0] v;
        logic wr;
        wr = kind[1];
        step();
        mem_read = kind[0]; mem_write = kind[1];
        lru_o = lru; valid_o = val; dirty_o = dty;
        hit_o = (hitway >= 0) ? (4'b0001 << hitway) : 4'b0000;
        if (hitway >= 0) begin
            v = 2'(hitway);
        end else begin
            step();
            pend_miss = 1'b1;
            v = vict_tab[lru];
            if (val[v] && dty[v]) begin
                for (int k = 0; k < wbn; k++) begin
                    step();
                    pmem_resp = (k == wbn - 1);
                    e_pw = 1'b1; e_am = addr_of(v); e_do = data_of(v);
                    if (k == wbn - 1) e_dl[v] = 1'b1;
                end
            end
            for (int k = 0; k < filln; k++) begin
                step();
                pmem_resp = (k == filln - 1);
                e_pr = 1'b1; e_di = dimux::pmem_rdata_from_mem;
                if (k == filln - 1) begin
                    e_we[{v, 1'b0} +: 2] = wemux::ones;
                    e_tl[v] = 1'b1; e_vl[v] = 1'b1; e_vi[v] = 1'b1; e_dl[v] = 1'b1;
                end
            end
            step();
            pmem_resp = 1'b0;
            hit_o = 4'b0001 << v;
            valid_o[v] = 1'b1;
            dirty_o[v] = 1'b0;
        end
        if (hitway >= 0) step();
        hit_cycle(wr, v);
        step();
        mem_read = 1'b0; mem_write = 1'b0; hit_o = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit_o = '0; valid_o = '0; dirty_o = '0; lru_o = '0;
        m_hits = '0; m_miss = '0; pend_hit = 1'b0; pend_miss = 1'b0;
        exp_default();
        step();
        step();
        rst = 1'b1;
        exp_on = 1'b1;
        chk("reset_hit_count", hit_count, 32'd0);

        txn(1, 2, 3'b000, 4'b0100, 4'b0000, 0, 0);               // read hit way2
        chk("lit_hit_after_read", hit_count, 32'd1);
        txn(2, 1, 3'b000, 4'b0010, 4'b0000, 0, 0);               // write hit way1
        txn(1, -1, 3'b000, 4'b0111, 4'b0000, 0, 3);              // clean miss, victim 3
        txn(2, -1, 3'b001, 4'b1111, 4'b0010, 2, 2);              // dirty miss, victim 1
        chk("lit_hits_after_dirty", hit_count, 32'd4);
        chk("lit_miss_after_dirty", miss_count, 32'd2);
        txn(3, 0, 3'b000, 4'b0001, 4'b0000, 0, 0);               // read+write is a write
        txn(1, -1, 3'b100, 4'b1111, 4'b1011, 0, 1);              // valid clean victim 2
        txn(2, -1, 3'b111, 4'b1111, 4'b0001, 1, 1);              // dirty victim 0, 1-cycle pmem
        chk("lit_sat_hits", 32'(s_hit_count), 32'd3);
        chk("lit_sat_miss", 32'(s_miss_count), 32'd3);
        chk("lit_hits_total", hit_count, 32'd7);

        step(); mem_read = 1'b1;                                 // request withdrawn in CHECK
        step(); mem_read = 1'b0;
        step();

        step(); mem_read = 1'b1; lru_o = 3'b000; valid_o = '0; dirty_o = '0; hit_o = '0;
        step(); pend_miss = 1'b1;
        step(); e_pr = 1'b1; e_di = dimux::pmem_rdata_from_mem;
        step(); e_pr = 1'b1; e_di = dimux::pmem_rdata_from_mem; rst = 1'b0; mem_read = 1'b0;
        step(); rst = 1'b1; pmem_resp = 1'b1;                    // spurious response in IDLE
        chk("lit_hits_after_rst", hit_count, 32'd0);
        chk("lit_miss_after_rst", miss_count, 32'd0);
        step(); pmem_resp = 1'b0;
        step();
        txn(1, 3, 3'b000, 4'b1000, 4'b0000, 0, 0);               // read hit way3 after reset
        chk("lit_hit_after_rst_txn", hit_count, 32'd1);
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
